// File: rtl/suite_pkg.sv
// Purpose : shared types and defaults for the image-BRAM arbiter (load FSM states, write-FIFO entry).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package suite_pkg;

    localparam int MEM_AW     = 17;   // byte address width of the image BRAM
    localparam int FIFO_DEPTH = 8;    // download write-FIFO entries

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        FLUSH,
        DONE
    } load_state_t;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [7:0]        data;
    } wr_entry_t;

endpackage

// File: rtl/suite_wr_fifo.sv
// Purpose : in-order synchronous FIFO of download write entries {addr,data}.
// Latency : pop_dat_o shows the head entry combinationally; push visible to pop one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full_o/empty_o.
// Ports   : push_i/push_dat_i in, pop_i/pop_dat_o out, full_o/empty_o/count_o status.
module suite_wr_fifo
    import suite_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,        // power of 2, >= 4
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push_i,
    input  wr_entry_t       push_dat_i,
    input  logic            pop_i,
    output wr_entry_t       pop_dat_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CW-1:0]   count_o
);

    wr_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/suite_mem_arbiter.sv
// Purpose : shares the single-port image BRAM between video reads (always win) and HPS download writes
//           (queued in a write FIFO and drained into idle cycles); sequences a load start/flush/done.
// Latency : vid_req sampled at edge N -> vid_valid/vid_data at edge N+3; queued writes issue one per idle cycle.
// Backpressure: ioctl_wait (registered) asserts at FIFO_DEPTH-2 entries; bytes arriving when full are dropped
//           and flagged on sticky overflow.
// Ports   : ioctl_* download stream in, ioctl_wait out; vid_req/vid_addr in, vid_data/vid_valid out;
//           mem_addr/mem_we/mem_wdata registered BRAM port, mem_rdata in; load_done/overflow/bytes_loaded status.
module suite_mem_arbiter #(
    parameter int MEM_WORDS  = 2 ** suite_pkg::MEM_AW,  // writes at or above this address are dropped
    parameter int FIFO_DEPTH = suite_pkg::FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ioctl_download,
    input  logic                         ioctl_wr,
    input  logic [suite_pkg::MEM_AW-1:0] ioctl_addr,
    input  logic [7:0]                   ioctl_data,
    output logic                         ioctl_wait,
    input  logic                         vid_req,
    input  logic [suite_pkg::MEM_AW-1:0] vid_addr,
    output logic [7:0]                   vid_data,
    output logic                         vid_valid,
    output logic [suite_pkg::MEM_AW-1:0] mem_addr,
    output logic                         mem_we,
    output logic [7:0]                   mem_wdata,
    input  logic [7:0]                   mem_rdata,
    output logic                         load_done,
    output logic                         overflow,
    output logic [suite_pkg::MEM_AW:0]   bytes_loaded
);
    import suite_pkg::*;

    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [MEM_AW:0] WORDS_LIM = (MEM_AW + 1)'(MEM_WORDS);
    localparam logic [CW-1:0]   WAIT_LVL  = CW'(FIFO_DEPTH - 2);
    localparam logic [MEM_AW:0] BYTES_MAX = '1;

    wr_entry_t          push_dat;
    wr_entry_t          pop_dat;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      count_nxt;
    logic               push_req;
    logic               push;
    logic               drop;
    logic               pop;

    // A full FIFO drops the byte even if a pop frees a slot in the same cycle.
    assign push_req  = ioctl_wr & ioctl_download & ({1'b0, ioctl_addr} < WORDS_LIM);
    assign push      = push_req & ~fifo_full;
    assign drop      = push_req & fifo_full;
    assign pop       = ~vid_req & ~fifo_empty;
    assign count_nxt = fifo_count + CW'(push) - CW'(pop);
    assign push_dat  = '{addr: ioctl_addr, data: ioctl_data};

    suite_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (pop_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // ---------------- grant mux: video read beats a FIFO drain ----------------
    logic [MEM_AW-1:0]  mem_addr_q,  mem_addr_d;
    logic               mem_we_q,    mem_we_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;

    always_comb begin
        mem_addr_d  = mem_addr_q;     // idle cycles keep the last address
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (vid_req) begin
            mem_addr_d = vid_addr;
        end else if (pop) begin
            mem_addr_d  = pop_dat.addr;
            mem_wdata_d = pop_dat.data;
            mem_we_d    = 1'b1;
        end
    end

    // ---------------- read return pipeline ----------------
    // [0]: address on BRAM, [1]: mem_rdata valid (captured into rdata_q), [2]: drive vid_* next edge.
    logic [2:0]         rd_pipe_q;
    logic [7:0]         rdata_q;
    logic               vid_valid_q;
    logic [7:0]         vid_data_q;
    logic               ioctl_wait_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            rd_pipe_q    <= '0;
            rdata_q      <= '0;
            vid_valid_q  <= 1'b0;
            vid_data_q   <= '0;
            ioctl_wait_q <= 1'b0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_pipe_q    <= {rd_pipe_q[1:0], vid_req};
            if (rd_pipe_q[1]) rdata_q <= mem_rdata;
            vid_valid_q  <= rd_pipe_q[2];
            if (rd_pipe_q[2]) vid_data_q <= rdata_q;
            // Two entries of margin absorb the HPS reaction delay to ioctl_wait.
            ioctl_wait_q <= (count_nxt >= WAIT_LVL);
        end
    end

    // ---------------- load sequencer ----------------
    load_state_t        state_q;
    logic               dl_q;
    logic               load_done_q;
    logic               overflow_q;
    logic [MEM_AW:0]    bytes_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dl_q        <= 1'b0;
            load_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            bytes_q     <= '0;
        end else begin
            dl_q        <= ioctl_download;
            load_done_q <= 1'b0;
            overflow_q  <= overflow_q | drop;
            if (push && bytes_q != BYTES_MAX) begin
                bytes_q <= bytes_q + {{MEM_AW{1'b0}}, 1'b1};
            end
            case (state_q)
                IDLE: begin
                    // New load: status restarts, but a byte arriving with the rising edge still counts.
                    if (ioctl_download && !dl_q) begin
                        state_q    <= LOADING;
                        overflow_q <= drop;
                        bytes_q    <= {{MEM_AW{1'b0}}, push};
                    end
                end
                LOADING: begin
                    if (!ioctl_download) state_q <= FLUSH;
                end
                FLUSH: begin
                    // Done only once the last popped write has actually left on mem_we.
                    if (ioctl_download) begin
                        state_q <= LOADING;
                    end else if (fifo_empty && !mem_we_q) begin
                        state_q     <= DONE;
                        load_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign vid_valid    = vid_valid_q;
    assign vid_data     = vid_data_q;
    assign ioctl_wait   = ioctl_wait_q;
    assign load_done    = load_done_q;
    assign overflow     = overflow_q;
    assign bytes_loaded = bytes_q;

endmodule
